// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory access controller:
// FSM state encoding, request kinds and the request-priority helpers.
package mem_access_ctrl_pkg;

    // Controller states: one idle state plus one state per issued beat.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR    = 3'd2,
        S_W64_A = 3'd3,
        S_W64_B = 3'd4
    } state_e;

    // Request kinds, listed from highest to lowest priority.
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_W64  = 2'd1,
        REQ_WR   = 2'd2,
        REQ_RD   = 2'd3
    } req_e;

    // Byte-offset masks that must be zero for an aligned access.
    localparam logic [2:0] ALIGN_MASK_32 = 3'b011;
    localparam logic [2:0] ALIGN_MASK_64 = 3'b111;

    // Priority: 64-bit store, then 32-bit store, then 32-bit load.
    function automatic req_e pick_req(input logic w64, input logic wr, input logic rd);
        if (w64)     return REQ_W64;
        else if (wr) return REQ_WR;
        else if (rd) return REQ_RD;
        else         return REQ_NONE;
    endfunction

    // True when more than one request line is asserted at once.
    function automatic logic multi_req(input logic w64, input logic wr, input logic rd);
        return (w64 & wr) | (w64 & rd) | (wr & rd);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_beat_timer.sv
// Per-beat wait counter. Cleared when a beat starts, advanced on every
// busy cycle in which memory does not answer. expired_o flags the cycle
// whose missing answer brings the count to MAX_WAIT, so a beat that never
// sees mem_ready is abandoned on its MAX_WAIT-th busy cycle.
module beat_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic start_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear on beat start, saturating increment on a wait cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        count_d = count_q;
        if (start_i) begin
            count_d = '0;
        end else if (tick_i && (count_q != CW'(MAX_WAIT))) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register, cleared asynchronously by reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!Rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = tick_i && (count_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage memory access controller. Turns 32-bit loads/stores and 64-bit
// stores from the pipeline into single-word memory beats, stalls the
// pipeline until the access finishes, captures load data and keeps sticky
// error flags for misalignment, timeout and conflicting requests.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter bit          HI_FIRST = 1'b0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemWrite64,
    input  logic [31:0] Adrs_MEM,
    input  logic [31:0] Rt_data_MEM,
    input  logic [63:0] Rt_data64_MEM,
    input  logic        Err_clr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        Stall,
    output logic [31:0] Rd_data_MEM,
    output logic        Rd_valid,
    output logic        Err_align,
    output logic        Err_timeout,
    output logic        Err_illegal
);

    state_e state_q;
    state_e state_d;
    req_e   req_sel;

    logic        beat_start;
    logic        beat_tick;
    logic        beat_expired;
    logic        align_evt;
    logic        illegal_evt;
    logic        timeout_evt;
    logic        rd_capture;

    logic [31:0] rd_data_q;
    logic        rd_valid_q;
    logic        err_align_q;
    logic        err_timeout_q;
    logic        err_illegal_q;

    // Beat addresses and data. The pipeline is frozen while busy, so these
    // stay stable for as long as a beat waits for mem_ready.
    logic [31:0] addr_word;
    logic [31:0] addr_hi;
    logic [31:0] first_addr;
    logic [31:0] first_data;
    logic [31:0] second_addr;
    logic [31:0] second_data;

    assign addr_word   = {Adrs_MEM[31:2], 2'b00};
    assign addr_hi     = addr_word + 32'd4;
    assign first_addr  = HI_FIRST ? addr_hi              : addr_word;
    assign first_data  = HI_FIRST ? Rt_data64_MEM[63:32] : Rt_data64_MEM[31:0];
    assign second_addr = HI_FIRST ? addr_word            : addr_hi;
    assign second_data = HI_FIRST ? Rt_data64_MEM[31:0]  : Rt_data64_MEM[63:32];

    assign req_sel = pick_req(MemWrite64, MemWrite, MemRead);

    beat_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_beat_timer (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .start_i   (beat_start),
        .tick_i    (beat_tick),
        .expired_o (beat_expired)
    );

    // Next state, beat outputs, stall and error events.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        Stall       = 1'b0;
        beat_start  = 1'b0;
        beat_tick   = 1'b0;
        align_evt   = 1'b0;
        illegal_evt = 1'b0;
        timeout_evt = 1'b0;
        rd_capture  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Rst_n gates acceptance so nothing stalls or starts while reset is held.
                if (Rst_n) begin
                    illegal_evt = multi_req(MemWrite64, MemWrite, MemRead);
                    case (req_sel)
                        REQ_W64: begin
                            if ((Adrs_MEM[2:0] & ALIGN_MASK_64) != 3'b000) begin
                                align_evt = 1'b1;
                            end else begin
                                state_d    = S_W64_A;
                                beat_start = 1'b1;
                                Stall      = 1'b1;
                            end
                        end
                        REQ_WR, REQ_RD: begin
                            if ((Adrs_MEM[2:0] & ALIGN_MASK_32) != 3'b000) begin
                                align_evt = 1'b1;
                            end else begin
                                state_d    = (req_sel == REQ_WR) ? S_WR : S_RD;
                                beat_start = 1'b1;
                                Stall      = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            S_RD, S_WR, S_W64_A, S_W64_B: begin
                mem_req   = 1'b1;
                Stall     = 1'b1;
                beat_tick = !mem_ready;

                case (state_q)
                    S_RD: begin
                        mem_addr = addr_word;
                    end
                    S_WR: begin
                        mem_we    = 1'b1;
                        mem_addr  = addr_word;
                        mem_wdata = Rt_data_MEM;
                    end
                    S_W64_A: begin
                        mem_we    = 1'b1;
                        mem_addr  = first_addr;
                        mem_wdata = first_data;
                    end
                    default: begin
                        mem_we    = 1'b1;
                        mem_addr  = second_addr;
                        mem_wdata = second_data;
                    end
                endcase

                if (mem_ready) begin
                    if (state_q == S_W64_A) begin
                        // First half accepted: start the second beat, pipeline stays frozen.
                        state_d    = S_W64_B;
                        beat_start = 1'b1;
                    end else begin
                        // Final beat done: release the pipeline exactly once.
                        state_d    = S_IDLE;
                        Stall      = 1'b0;
                        rd_capture = (state_q == S_RD);
                    end
                end else if (beat_expired) begin
                    // Abandon the whole access; a pending upper word is never written.
                    state_d     = S_IDLE;
                    Stall       = 1'b0;
                    timeout_evt = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load data capture and one-cycle valid pulse.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_capture;
            if (rd_capture) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            err_align_q   <= (err_align_q   & ~Err_clr) | align_evt;
            err_timeout_q <= (err_timeout_q & ~Err_clr) | timeout_evt;
            err_illegal_q <= (err_illegal_q & ~Err_clr) | illegal_evt;
        end
    end

    assign Rd_data_MEM = rd_data_q;
    assign Rd_valid    = rd_valid_q;
    assign Err_align   = err_align_q;
    assign Err_timeout = err_timeout_q;
    assign Err_illegal = err_illegal_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed accesses push the expected
// memory beats and load results into queues; a negedge monitor pops and
// compares whenever the DUT completes a beat or pulses Rd_valid.
module tb_mem_access_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic        MemWrite64;
    logic [31:0] Adrs_MEM;
    logic [31:0] Rt_data_MEM;
    logic [63:0] Rt_data64_MEM;
    logic        Err_clr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        Stall;
    logic [31:0] Rd_data_MEM;
    logic        Rd_valid;
    logic        Err_align;
    logic        Err_timeout;
    logic        Err_illegal;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk_data;
    } beat_t;

    beat_t       beat_q[$];
    logic [31:0] rd_q[$];

    int n_cmp     = 0;
    int n_fail    = 0;
    int stall_cnt = 0;
    int req_cnt   = 0;
    int rdv_cnt   = 0;

    mem_access_ctrl #(
        .MAX_WAIT (15),
        .HI_FIRST (1'b0)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .MemWrite64    (MemWrite64),
        .Adrs_MEM      (Adrs_MEM),
        .Rt_data_MEM   (Rt_data_MEM),
        .Rt_data64_MEM (Rt_data64_MEM),
        .Err_clr       (Err_clr),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .Stall         (Stall),
        .Rd_data_MEM   (Rd_data_MEM),
        .Rd_valid      (Rd_valid),
        .Err_align     (Err_align),
        .Err_timeout   (Err_timeout),
        .Err_illegal   (Err_illegal)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: cycle statistics plus scoreboard comparison of beats and loads.
    always @(negedge Clk) begin : monitor
        beat_t       b;
        logic [31:0] r;
        if (Stall)   stall_cnt++;
        if (mem_req) req_cnt++;
        if (mem_req && mem_ready) begin
            if (beat_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_beat: got addr 0x%08h we %0b, expected no beat", mem_addr, mem_we);
            end else begin
                b = beat_q.pop_front();
                check("beat_we", 32'(mem_we), 32'(b.we));
                check("beat_addr", mem_addr, b.addr);
                if (b.chk_data) check("beat_wdata", mem_wdata, b.data);
            end
        end
        if (Rd_valid) begin
            rdv_cnt++;
            if (rd_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got data 0x%08h, expected no pulse", Rd_data_MEM);
            end else begin
                r = rd_q.pop_front();
                check("rd_data", Rd_data_MEM, r);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemWrite64    = 1'b0;
        Err_clr       = 1'b0;
        mem_ready     = 1'b0;
        mem_rdata     = 32'h1234_5678;
        Adrs_MEM      = '0;
        Rt_data_MEM   = '0;
        Rt_data64_MEM = '0;
    endtask

    task automatic push_beat(input logic we, input logic [31:0] addr, input logic [31:0] data, input logic chk);
        beat_t b;
        b.we       = we;
        b.addr     = addr;
        b.data     = data;
        b.chk_data = chk;
        beat_q.push_back(b);
    endtask

    // One 32-bit access whose beat sees mem_ready on busy cycle n.
    // Expected stall: the IDLE cycle plus n-1 waiting busy cycles = n.
    task automatic access32(input logic is_read, input logic [31:0] addr,
                            input logic [31:0] data, input int n);
        int s0, r0, v0;
        s0 = stall_cnt;
        r0 = req_cnt;
        v0 = rdv_cnt;
        MemRead     = is_read;
        MemWrite    = !is_read;
        Adrs_MEM    = addr;
        Rt_data_MEM = is_read ? 32'h0 : data;
        mem_ready   = 1'b0;
        push_beat(!is_read, addr, data, !is_read);
        if (is_read) rd_q.push_back(data);
        repeat (n) tick();
        mem_ready = 1'b1;
        if (is_read) mem_rdata = data;
        tick();
        idle_inputs();
        tick();
        check("acc_stall_cycles", 32'(stall_cnt - s0), 32'(n));
        check("acc_req_cycles", 32'(req_cnt - r0), 32'(n));
        check("acc_rd_valid_pulses", 32'(rdv_cnt - v0), 32'(is_read));
    endtask

    initial begin : stimulus
        int s0, r0, v0;

        // Reset: outputs quiet even with a request pending.
        Rst_n = 1'b1;
        idle_inputs();
        #1 Rst_n = 1'b0;
        MemRead   = 1'b1;
        Adrs_MEM  = 32'h10;
        mem_ready = 1'b1;
        #20;
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_stall", 32'(Stall), 32'h0);
        check("rst_rd_valid", 32'(Rd_valid), 32'h0);
        check("rst_rd_data", Rd_data_MEM, 32'h0);
        check("rst_errs", {29'b0, Err_align, Err_timeout, Err_illegal}, 32'h0);
        idle_inputs();
        @(posedge Clk);
        #1 Rst_n = 1'b1;

        // Store with mem_ready on the 3rd busy cycle: stall for 3 cycles.
        access32(1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 3);
        // Load answered on the 2nd busy cycle.
        access32(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 2);
        // Load answered immediately.
        access32(1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 1);
        check("no_errs_after_clean", {29'b0, Err_align, Err_timeout, Err_illegal}, 32'h0);

        // 64-bit store at the top of the address space, memory always ready.
        s0 = stall_cnt;
        r0 = req_cnt;
        MemWrite64    = 1'b1;
        Adrs_MEM      = 32'hFFFF_FFF8;
        Rt_data64_MEM = 64'h1122_3344_5566_7788;
        mem_ready     = 1'b1;
        push_beat(1'b1, 32'hFFFF_FFF8, 32'h5566_7788, 1'b1);
        push_beat(1'b1, 32'hFFFF_FFFC, 32'h1122_3344, 1'b1);
        repeat (3) tick();
        idle_inputs();
        check("w64_stall_cycles", 32'(stall_cnt - s0), 32'd2);
        check("w64_req_cycles", 32'(req_cnt - r0), 32'd2);
        check("rd_data_hold", Rd_data_MEM, 32'h0BAD_CAFE);

        // Misalignment: no beat, no stall, sticky flag, clear behaviour.
        s0 = stall_cnt;
        r0 = req_cnt;
        MemWrite    = 1'b1;
        Adrs_MEM    = 32'h0000_0102;
        Rt_data_MEM = 32'h0000_0055;
        #3;
        check("align_stall_comb", 32'(Stall), 32'h0);
        check("align_mem_req", 32'(mem_req), 32'h0);
        tick();
        idle_inputs();
        check("err_align_set", 32'(Err_align), 32'h1);
        Err_clr = 1'b1;
        tick();
        idle_inputs();
        check("err_align_cleared", 32'(Err_align), 32'h0);
        MemWrite64 = 1'b1;
        Adrs_MEM   = 32'h0000_0104;
        tick();
        idle_inputs();
        check("err_align_w64_word_aligned", 32'(Err_align), 32'h1);
        Err_clr  = 1'b1;
        MemWrite = 1'b1;
        Adrs_MEM = 32'h0000_0102;
        tick();
        idle_inputs();
        check("err_align_event_beats_clear", 32'(Err_align), 32'h1);
        Err_clr = 1'b1;
        tick();
        idle_inputs();
        check("err_align_final_clear", 32'(Err_align), 32'h0);
        check("align_stall_total", 32'(stall_cnt - s0), 32'h0);
        check("align_req_total", 32'(req_cnt - r0), 32'h0);

        // Store and load together: flag set, store wins, no load result.
        s0 = stall_cnt;
        v0 = rdv_cnt;
        MemWrite    = 1'b1;
        MemRead     = 1'b1;
        Adrs_MEM    = 32'h0000_0200;
        Rt_data_MEM = 32'hA5A5_5A5A;
        mem_ready   = 1'b1;
        push_beat(1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 1'b1);
        repeat (2) tick();
        idle_inputs();
        tick();
        check("err_illegal_set", 32'(Err_illegal), 32'h1);
        check("illegal_no_align", 32'(Err_align), 32'h0);
        check("illegal_no_load", 32'(rdv_cnt - v0), 32'h0);
        check("illegal_stall_cycles", 32'(stall_cnt - s0), 32'd1);
        Err_clr = 1'b1;
        tick();
        idle_inputs();
        check("err_illegal_cleared", 32'(Err_illegal), 32'h0);

        // Load with memory never ready: abort on the 15th busy cycle.
        s0 = stall_cnt;
        r0 = req_cnt;
        v0 = rdv_cnt;
        MemRead   = 1'b1;
        Adrs_MEM  = 32'h0000_0080;
        mem_ready = 1'b0;
        repeat (16) tick();
        idle_inputs();
        check("timeout_flag", 32'(Err_timeout), 32'h1);
        check("timeout_back_idle", 32'(mem_req), 32'h0);
        check("timeout_req_cycles", 32'(req_cnt - r0), 32'd15);
        check("timeout_stall_cycles", 32'(stall_cnt - s0), 32'd15);
        check("timeout_no_load", 32'(rdv_cnt - v0), 32'h0);
        Err_clr = 1'b1;
        tick();
        idle_inputs();
        check("err_timeout_cleared", 32'(Err_timeout), 32'h0);

        // Fresh access after an abort works normally.
        access32(1'b0, 32'h0000_0104, 32'h0000_1234, 1);

        // Reset while the upper half of a 64-bit store waits.
        MemWrite64    = 1'b1;
        Adrs_MEM      = 32'h0000_0300;
        Rt_data64_MEM = 64'hAAAA_0001_BBBB_0002;
        mem_ready     = 1'b1;
        push_beat(1'b1, 32'h0000_0300, 32'hBBBB_0002, 1'b1);
        repeat (2) tick();
        mem_ready = 1'b0;
        tick();
        check("w64b_waiting", 32'(mem_req), 32'h1);
        Rst_n = 1'b0;
        #1;
        check("w64b_reset_mem_req", 32'(mem_req), 32'h0);
        check("w64b_reset_stall", 32'(Stall), 32'h0);
        mem_ready = 1'b1;
        repeat (2) tick();
        check("w64b_reset_rd_data", Rd_data_MEM, 32'h0);
        idle_inputs();
        mem_ready = 1'b1;
        Rst_n = 1'b1;
        r0 = req_cnt;
        repeat (3) tick();
        idle_inputs();
        check("w64b_no_more_beats", 32'(req_cnt - r0), 32'h0);

        // First request after reset is served.
        access32(1'b1, 32'h0000_0008, 32'h7777_0001, 1);

        tick();
        check("beat_queue_empty", 32'(beat_q.size()), 32'h0);
        check("rd_queue_empty", 32'(rd_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum cycles any single beat may wait for mem_ready before it is aborted.
REQ-002 Parameter HI_FIRST, default 0: for a 64-bit store, 1 issues the upper word first and 0 issues the lower word first.
REQ-003 Ports (name  direction  width  meaning):
- Clk  in  1  single clock; all state changes on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- MemRead  in  1  MEM-stage 32-bit load request.
- MemWrite  in  1  MEM-stage 32-bit store request.
- MemWrite64  in  1  MEM-stage 64-bit store request.
- Adrs_MEM  in  32  byte address.
- Rt_data_MEM  in  32  store data, 32-bit.
- Rt_data64_MEM  in  64  store data, 64-bit.
- Err_clr  in  1  clears the sticky error flags.
- mem_req  out  1  a memory beat is valid.
- mem_we  out  1  the beat is a write.
- mem_addr  out  32  word-aligned beat address.
- mem_wdata  out  32  beat write data.
- mem_ready  in  1  memory accepts or completes the beat this cycle.
- mem_rdata  in  32  load data, valid with mem_ready.
- Stall  out  1  freezes the IF to EXE/MEM pipeline registers.
- Rd_data_MEM  out  32  captured load data.
- Rd_valid  out  1  one-cycle pulse when Rd_data_MEM updates.
- Err_align  out  1  sticky misalignment flag.
- Err_timeout  out  1  sticky timeout flag.
- Err_illegal  out  1  sticky flag for more than one request asserted at once.

Function
REQ-004 States: IDLE, RD, WR, W64_A, W64_B.
REQ-005 In IDLE, request priority is MemWrite64, then MemWrite, then MemRead.
REQ-006 In IDLE, more than one request asserted sets Err_illegal; the highest-priority request still executes.
REQ-007 Misaligned requests (32-bit with Adrs_MEM[1:0]!=0; 64-bit with Adrs_MEM[2:0]!=0) set Err_align, perform no beat, assert no Stall, and keep the state at IDLE.
REQ-008 A valid request moves IDLE to RD, WR or W64_A on the next edge; Stall is combinationally high in that IDLE cycle.
REQ-009 In RD, WR, W64_A and W64_B, mem_req is 1.
REQ-010 mem_we is 0 in RD and 1 in the write states.
REQ-011 mem_addr and mem_wdata are held stable until mem_ready.
REQ-012 W64 beat addresses: lower word at Adrs_MEM, upper word at Adrs_MEM+4, computed modulo 2^32.
REQ-013 W64 beat data: lower word is Rt_data64_MEM[31:0], upper word is Rt_data64_MEM[63:32]; HI_FIRST selects the order.
REQ-014 mem_ready in W64_A moves the state to W64_B.
REQ-015 mem_ready in RD, WR or W64_B returns the state to IDLE.
REQ-016 Stall is high in every busy cycle except the cycle in which the final beat sees mem_ready.
REQ-017 Consequence of REQ-016: the pipeline advances exactly once per access and the same command is never reissued.
REQ-018 In RD with mem_ready, mem_rdata is registered into Rd_data_MEM and Rd_valid pulses for the next cycle.
REQ-019 Rd_data_MEM holds its value otherwise.
REQ-020 A per-beat wait counter clears on each beat start and increments each busy cycle without mem_ready.
REQ-021 When the wait counter reaches MAX_WAIT, the access aborts: Err_timeout sets, Stall drops that cycle, and the state returns to IDLE.
REQ-022 A timeout during W64_B leaves the upper word unwritten; no retry is made.
REQ-023 Error flags are sticky; Err_clr clears them.
REQ-024 A new error event in the same cycle as Err_clr wins: the flag stays set.
REQ-025 Requests arriving while busy are ignored; the pipeline is stalled, so the inputs are held.

Reset
REQ-026 Rst_n low forces, asynchronously: state IDLE, wait counter 0, Rd_data_MEM 0, Rd_valid 0, all error flags 0.
REQ-027 With Rst_n low, mem_req and Stall are 0 and no beat is issued.
REQ-028 Reset mid-access abandons the access; any partial 64-bit write is not completed.
REQ-029 The first request is sampled on the first rising edge after Rst_n deasserts.

Structure
REQ-030 The state encoding and the request-priority constants reside in the shared processor package.
REQ-031 The wait counter is one sub-module, beat_timer, with start, tick, count and expired.
REQ-032 Everything else is one FSM with a registered state and combinational outputs.

Verification
REQ-033 Scenario: MemWrite, Adrs_MEM=0x100, data 0xDEADBEEF, mem_ready on the 3rd cycle -> one write beat to 0x100, Stall high for exactly 3 cycles.
REQ-034 Scenario: MemWrite64, Adrs 0xFFFFFFF8, data 0x11223344_55667788, HI_FIRST=0, mem_ready always 1 -> beats (0xFFFFFFF8, 0x55667788) then (0xFFFFFFFC, 0x11223344); Stall high for 2 cycles.
REQ-035 Scenario: MemRead, Adrs 0x40, mem_rdata 0xCAFEF00D on the 2nd cycle -> Rd_data_MEM=0xCAFEF00D with a one-cycle Rd_valid pulse.
REQ-036 Scenario: MemWrite with Adrs 0x102 -> no mem_req, Stall 0, Err_align=1; Err_clr then clears it.
REQ-037 Scenario: MemRead with mem_ready held 0, MAX_WAIT=15 -> abort after 15 busy cycles with Err_timeout=1 and state IDLE.
REQ-038 Scenario: Rst_n pulsed low during W64_B -> immediate IDLE with mem_req=0 and Stall=0, and no further beat.
